fetch_pc_ctrl: RTL
==================

Name: fetch_pc_ctrl

Overview:
- Fetch-stage sequencer: owns the fetch PC and issues one instruction-cache request at a time.
- Applies redirects in priority order: exception > branch mispredict > predictor taken > sequential.
- Squashes stale in-flight responses.
- Delivers instructions to the decoder through an output register plus a 1-entry skid buffer, honouring decoder stall.
- Sits between the icache fetch interface and the fetch-to-decode interface, inside fetch_top.

Parameters:
ADDR, 32, address width.
INST, 32, instruction width.
RESET_VEC, 0 (ADDR bits), PC fetched first after reset.
INST_BYTES, 4, sequential PC increment.

Ports:
clk  in  1  clock; the only clock.
reset_  in  1  reset; synchronous, active-low.
exc_redirect  in  1  exception/trap redirect request.
exc_pc  in  ADDR  exception target.
br_redirect  in  1  branch mispredict redirect.
br_pc  in  ADDR  corrected target.
pred_taken  in  1  predictor: the PC being returned this cycle is taken.
pred_target  in  ADDR  predicted target.
ic_req  out  1  icache request valid.
ic_pc  out  ADDR  request address.
ic_ready  in  1  icache accepts the request this cycle.
ic_valid  in  1  icache response valid; single-cycle pulse that must be consumed.
ic_inst  in  INST  response instruction.
dec_valid  out  1  instruction valid to decoder.
dec_pc  out  ADDR  PC of dec_inst.
dec_inst  out  INST  instruction.
dec_stall  in  1  decoder cannot accept; hold outputs.

Behaviour:
- Interface: one clock (clk); reset (reset_) is synchronous and active-low.
- Reset (reset_=0 at posedge):
  - state=IDLE, pc=RESET_VEC, skid empty.
  - dec_valid=0, dec_pc=0, dec_inst=0, ic_req=0, ic_pc=RESET_VEC.
- States: IDLE, REQ, WAIT, DROP.
  - IDLE -> REQ unconditionally. ic_req first rises 2 cycles after reset_ rises.
  - REQ:
    - ic_req = !skid_valid; ic_pc = pc.
    - ic_req & ic_ready -> WAIT.
    - A redirect in the same cycle as acceptance -> DROP.
  - WAIT: on ic_valid, capture {pc, ic_inst}, then pc <= pred_taken ? pred_target : pc+INST_BYTES (mod 2^ADDR), then -> REQ.
  - DROP: the next ic_valid is discarded without capture -> REQ. pc is unchanged by the dropped response.
- Redirect (exc_redirect|br_redirect), any state except IDLE:
  - pc <= exc_redirect ? exc_pc : br_pc.
  - dec_valid and skid cleared next cycle, regardless of dec_stall.
  - WAIT -> DROP. REQ with no acceptance stays REQ and next cycle requests the new pc. DROP stays DROP.
  - A redirect in the same cycle as ic_valid in WAIT also discards that response and -> REQ.
  - Redirect in IDLE updates pc only.
- Output path:
  - Captured response enters the dec register if (!dec_valid | !dec_stall), else the skid.
  - Skid drains to the dec register on the first cycle dec_stall=0, before any new capture. This preserves order.
  - ic_req is suppressed while the skid is full.
  - Latency: ic_valid at t -> dec_valid at t+1 (register free); next ic_req at t+1.
- dec_valid/dec_pc/dec_inst are held stable while dec_stall=1.
- ic_valid outside WAIT/DROP is ignored.
- ic_req stays high until ic_ready; ic_pc changes while unaccepted only on redirect.

Test Plan:
- Reset release, ic_ready=1, 2-cycle icache latency, no stall -> ic_pc sequence 0x0,0x4,0x8; dec_pc 0x0,0x4,0x8, each 1 cycle after ic_valid.
- pred_taken=1, pred_target=0x100 on response for 0x4 -> next ic_pc=0x100, dec_pc order 0x4,0x100.
- br_redirect(br_pc=0x200) during WAIT for 0x8 -> ic_valid for 0x8 dropped, dec_valid never shows 0x8, next ic_pc=0x200.
- exc_redirect(0x80) and br_redirect(0x200) in same cycle -> next ic_pc=0x80; dec_valid=0 next cycle.
- dec_stall=1 for 6 cycles over two responses (0x0,0x4) -> dec_pc held at 0x0, skid holds 0x4, ic_req low while skid full; release -> 0x0 then 0x4 delivered, requests resume at 0x8.
- reset_=0 asserted mid-WAIT -> next cycle all outputs at reset values; pending ic_valid ignored; fetch restarts at RESET_VEC.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl
// Description : Fetch-stage sequencer. Owns the fetch PC, issues one icache
//               request at a time, applies prioritised redirects, squashes
//               stale responses and feeds the decoder through an output
//               register backed by a 1-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl #(
  parameter int              ADDR       = 32,
  parameter int              INST       = 32,
  parameter logic [ADDR-1:0] RESET_VEC  = '0,
  parameter int              INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            exc_redirect,
  input  logic [ADDR-1:0] exc_pc,
  input  logic            br_redirect,
  input  logic [ADDR-1:0] br_pc,
  input  logic            pred_taken,
  input  logic [ADDR-1:0] pred_target,
  output logic            ic_req,
  output logic [ADDR-1:0] ic_pc,
  input  logic            ic_ready,
  input  logic            ic_valid,
  input  logic [INST-1:0] ic_inst,
  output logic            dec_valid,
  output logic [ADDR-1:0] dec_pc,
  output logic [INST-1:0] dec_inst,
  input  logic            dec_stall
);

  localparam logic [ADDR-1:0] c_inc = ADDR'(INST_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ADDR-1:0] r_pc;
  logic [ADDR-1:0] w_pc_nxt;
  logic            r_skid_valid;
  logic [ADDR-1:0] r_skid_pc;
  logic [INST-1:0] r_skid_inst;

  logic            w_redirect;
  logic [ADDR-1:0] w_redir_pc;
  logic            w_accept;
  logic            w_capture;
  logic            w_flush;
  logic            w_dec_free;

  // Exception outranks branch mispredict when both redirect together.
  assign w_redirect = exc_redirect | br_redirect;
  assign w_redir_pc = exc_redirect ? exc_pc : br_pc;
  assign ic_pc      = r_pc;
  assign w_accept   = ic_req & ic_ready;
  assign w_flush    = w_redirect & (r_state != S_IDLE);
  assign w_dec_free = ~dec_valid | ~dec_stall;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state, next-PC and request generation.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    ic_req      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (w_redirect) w_pc_nxt = w_redir_pc;
      end
      S_REQ: begin
        // Hold off new requests while the skid is occupied.
        ic_req = ~r_skid_valid;
        if (w_redirect) begin
          w_pc_nxt    = w_redir_pc;
          // An accepted request for the old PC is now stale.
          w_state_nxt = w_accept ? S_DROP : S_REQ;
        end else if (w_accept) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ic_valid) begin
          w_state_nxt = S_REQ;
          if (w_redirect) begin
            w_pc_nxt = w_redir_pc;
          end else begin
            w_capture = 1'b1;
            w_pc_nxt  = pred_taken ? pred_target : r_pc + c_inc;
          end
        end else if (w_redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        // The outstanding response is consumed and discarded; pc untouched.
        if (ic_valid)   w_state_nxt = S_REQ;
        if (w_redirect) w_pc_nxt    = w_redir_pc;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (!reset_) r_pc <= RESET_VEC;
    else         r_pc <= w_pc_nxt;
  end

  // Decode output register and skid buffer; skid drains before new captures.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      dec_valid    <= 1'b0;
      dec_pc       <= '0;
      dec_inst     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_inst  <= '0;
    end else if (w_flush) begin
      dec_valid    <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_dec_free) begin
      if (r_skid_valid) begin
        dec_valid    <= 1'b1;
        dec_pc       <= r_skid_pc;
        dec_inst     <= r_skid_inst;
        r_skid_valid <= w_capture;
        if (w_capture) begin
          r_skid_pc   <= r_pc;
          r_skid_inst <= ic_inst;
        end
      end else if (w_capture) begin
        dec_valid <= 1'b1;
        dec_pc    <= r_pc;
        dec_inst  <= ic_inst;
      end else begin
        dec_valid <= 1'b0;
      end
    end else if (w_capture) begin
      r_skid_valid <= 1'b1;
      r_skid_pc    <= r_pc;
      r_skid_inst  <= ic_inst;
    end
  end

endmodule
`default_nettype wire
